// File: rtl/pe_weight_loader_ctrl.sv
// Weight-load / run sequencer for the PE filter array: streams TAPS x CH weights, then runs.
// Optional macro PE_CTRL_RELOAD_EN lets a reload pulse in RUN restart the weight load.
module pe_weight_loader_ctrl #(
    parameter int unsigned TAPS   = 9,
    parameter int unsigned CH     = 4,
    parameter int unsigned MODE_W = 3,
    localparam int unsigned TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1,
    localparam int unsigned CH_W  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MODE_W-1:0] mode_i,
    input  logic              reload_i,
    input  logic              wt_src_valid_i,
    output logic              wt_src_ready_o,
    output logic              wt_we_o,
    output logic [TAP_W-1:0]  wt_addr_o,
    output logic [CH_W-1:0]   wt_ch_o,
    output logic              proc_en_o,
    output logic              load_done_o,
    output logic              busy_o,
    output logic              mode_err_o
);

    localparam logic [TAP_W-1:0] TapLast = TAP_W'(TAPS - 1);
    localparam logic [CH_W-1:0]  ChLast  = CH_W'(CH - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

    state_e            state_q;
    logic [MODE_W-1:0] mode_q;
    logic [TAP_W-1:0]  addr_q;
    logic [CH_W-1:0]   ch_q;
    logic              load_done_q;

    logic mode_chg;
    logic mode_onehot;
    logic reload_go;

    assign mode_chg    = (mode_i != mode_q);
    assign mode_onehot = (mode_q != '0) && ((mode_q & (mode_q - MODE_W'(1))) == '0);

`ifdef PE_CTRL_RELOAD_EN
    assign reload_go = reload_i;
`else
    logic unused_reload;
    assign unused_reload = reload_i;
    assign reload_go     = 1'b0;
`endif

    // A pending mode change blocks acceptance so the abort cycle never writes.
    assign wt_src_ready_o = (state_q == StLoad) && !mode_chg;
    assign wt_we_o        = wt_src_ready_o && wt_src_valid_i;
    assign wt_addr_o      = addr_q;
    assign wt_ch_o        = ch_q;
    assign proc_en_o      = (state_q == StRun);
    assign busy_o         = (state_q == StLoad);
    assign load_done_o    = load_done_q;
    assign mode_err_o     = (mode_q != '0) && !mode_onehot;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            mode_q      <= '0;
            addr_q      <= '0;
            ch_q        <= '0;
            load_done_q <= 1'b0;
        end else begin
            mode_q      <= mode_i;
            load_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (mode_onehot && !mode_chg) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    if (mode_chg) begin
                        state_q <= StIdle;
                        addr_q  <= '0;
                        ch_q    <= '0;
                    end else if (wt_we_o) begin
                        if (addr_q == TapLast) begin
                            addr_q <= '0;
                            if (ch_q == ChLast) begin
                                ch_q        <= '0;
                                state_q     <= StRun;
                                load_done_q <= 1'b1;
                            end else begin
                                ch_q <= ch_q + CH_W'(1);
                            end
                        end else begin
                            addr_q <= addr_q + TAP_W'(1);
                        end
                    end
                end
                StRun: begin
                    if (mode_chg) begin
                        state_q <= StIdle;
                    end else if (reload_go) begin
                        state_q <= StLoad;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    addr_q  <= '0;
                    ch_q    <= '0;
                end
            endcase
        end
    end

endmodule
